// File: rtl/rom_dl_ctrl.sv
// ROM download sequencer: registers the HPS ioctl byte stream into the core's
// ROM write port with a range check and region decode, and holds the arcade
// core in reset until a download has landed plus a fixed settling time. Menu
// and button soft resets are stretched through the same hold path.
module rom_dl_ctrl #(
    parameter int          EXP_BYTES   = 32768,
    parameter logic [15:0] RGN1_BASE   = 16'h4000,
    parameter logic [15:0] RGN2_BASE   = 16'h6000,
    parameter int          HOLD_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        soft_rst,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [1:0]  rgn_sel,
    output logic        core_reset,
    output logic        dl_busy,
    output logic        dl_done,
    output logic        dl_err
);

    localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [24:0]     EXP_A     = 25'(EXP_BYTES);
    localparam logic [16:0]     EXP_C     = 17'(EXP_BYTES);
    localparam logic [24:0]     R1_A      = {9'd0, RGN1_BASE};
    localparam logic [24:0]     R2_A      = {9'd0, RGN2_BASE};

    typedef enum logic [1:0] {BOOT, LOAD, HOLD, RUN} state_e;

    state_e        state_q, state_d;
    logic [15:0]   dn_addr_q, dn_addr_d;
    logic [7:0]    dn_data_q, dn_data_d;
    logic          dn_wr_q, dn_wr_d;
    logic [1:0]    rgn_q, rgn_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic [16:0]   byte_cnt_q, byte_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          soft_prev_q;

    logic          in_range;
    logic [16:0]   cnt_inc;
    logic [1:0]    rgn_dec;

    assign in_range = (ioctl_addr < EXP_A);
    // Byte counter saturates so a runaway stream can never wrap back to a "good" count.
    assign cnt_inc  = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 17'd1;
    assign rgn_dec  = (ioctl_addr < R1_A) ? 2'd0 :
                      (ioctl_addr < R2_A) ? 2'd1 : 2'd2;

    // Register file: state, write port, status and counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= BOOT;
            dn_addr_q   <= '0;
            dn_data_q   <= '0;
            dn_wr_q     <= 1'b0;
            rgn_q       <= 2'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            byte_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            soft_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dn_addr_q   <= dn_addr_d;
            dn_data_q   <= dn_data_d;
            dn_wr_q     <= dn_wr_d;
            rgn_q       <= rgn_d;
            err_q       <= err_d;
            done_q      <= done_d;
            byte_cnt_q  <= byte_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            soft_prev_q <= soft_rst;
        end
    end

    // Next-state logic; a rising download restarts LOAD from any state but BOOT's
    // own transition, and clears the status for the new image.
    always_comb begin
        state_d    = state_q;
        dn_addr_d  = dn_addr_q;
        dn_data_d  = dn_data_q;
        dn_wr_d    = 1'b0;
        rgn_d      = rgn_q;
        err_d      = err_q;
        done_d     = done_q;
        byte_cnt_d = byte_cnt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            BOOT: begin
                if (ioctl_download) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                end
            end
            LOAD: begin
                if (ioctl_wr) begin
                    byte_cnt_d = cnt_inc;
                    if (in_range) begin
                        dn_wr_d   = 1'b1;
                        dn_addr_d = ioctl_addr[15:0];
                        dn_data_d = ioctl_dout;
                        rgn_d     = rgn_dec;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Length check sees the count including a strobe on the falling cycle.
                if (!ioctl_download) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_LAST;
                    if (byte_cnt_d != EXP_C) err_d = 1'b1;
                end
            end
            HOLD: begin
                if (ioctl_download) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                end else if (soft_rst) begin
                    hold_cnt_d = HOLD_LAST;
                end else if (hold_cnt_q == '0) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (ioctl_download) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                end else if (soft_rst && !soft_prev_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = HOLD_LAST;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // soft_rst passes straight through in RUN so the core is held from the very
    // cycle of the request, with no gap before HOLD takes over.
    assign core_reset = (state_q != RUN) || soft_rst;
    assign dl_busy    = (state_q == LOAD);
    assign dn_addr    = dn_addr_q;
    assign dn_data    = dn_data_q;
    assign dn_wr      = dn_wr_q;
    assign rgn_sel    = rgn_q;
    assign dl_done    = done_q;
    assign dl_err     = err_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Self-checking bench for rom_dl_ctrl: boot quiet period, full load, short load,
// soft-reset stretch, region/range vector table, random load traffic and
// asynchronous reset mid-download.
module tb_rom_dl_ctrl;

    localparam int EXP  = 32768;
    localparam int HOLD = 1024;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        soft_rst;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [1:0]  rgn_sel;
    logic        core_reset;
    logic        dl_busy;
    logic        dl_done;
    logic        dl_err;

    int total = 0;
    int bad   = 0;

    rom_dl_ctrl #(
        .EXP_BYTES(EXP), .RGN1_BASE(16'h4000), .RGN2_BASE(16'h6000), .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .soft_rst(soft_rst),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .rgn_sel(rgn_sel),
        .core_reset(core_reset), .dl_busy(dl_busy), .dl_done(dl_done), .dl_err(dl_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        logic        exp_wr;
        logic [1:0]  exp_rgn;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected region from the address map.
    function automatic logic [1:0] region(input int a);
        if (a < 'h4000) return 2'd0;
        if (a < 'h6000) return 2'd1;
        return 2'd2;
    endfunction

    // Count cycles core_reset stays high after the current point.
    task automatic wait_run(input string nm, input int exp_n);
        int n = 0;
        while (core_reset && n < 5000) begin
            tick();
            n++;
        end
        chk(nm, n, exp_n);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_core_reset"}, core_reset, 1);
        chk({nm, "_dn_wr"},      dn_wr, 0);
        chk({nm, "_dn_addr"},    dn_addr, 0);
        chk({nm, "_dn_data"},    dn_data, 0);
        chk({nm, "_rgn"},        rgn_sel, 0);
        chk({nm, "_busy"},       dl_busy, 0);
        chk({nm, "_done"},       dl_done, 0);
        chk({nm, "_err"},        dl_err, 0);
    endtask

    initial begin
        vec_t vt[9];
        int   viol;
        int   sent;
        logic err_m;
        logic [7:0] d;

        vt[0] = '{25'h0000000, 8'h11, 1'b1, 2'd0, 1'b0};
        vt[1] = '{25'h0003FFF, 8'h22, 1'b1, 2'd0, 1'b0};
        vt[2] = '{25'h0004000, 8'h33, 1'b1, 2'd1, 1'b0};
        vt[3] = '{25'h0005FFF, 8'h44, 1'b1, 2'd1, 1'b0};
        vt[4] = '{25'h0006000, 8'h55, 1'b1, 2'd2, 1'b0};
        vt[5] = '{25'h0007FFF, 8'h66, 1'b1, 2'd2, 1'b0};
        vt[6] = '{25'h0008000, 8'hAA, 1'b0, 2'd2, 1'b1};
        vt[7] = '{25'h0000123, 8'h77, 1'b1, 2'd0, 1'b1};
        vt[8] = '{25'h1FFFFFF, 8'h88, 1'b0, 2'd0, 1'b1};

        RESET = 1'b1; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
        ioctl_dout = '0; soft_rst = 0;
        tick(); tick();
        chk_reset_vals("reset");
        RESET = 1'b0;

        // Power-up without a download: core stays held, no writes, soft resets ignored.
        viol = 0;
        for (int i = 0; i < 10000; i++) begin
            soft_rst   = ($urandom_range(0, 15) == 0);
            ioctl_wr   = ($urandom_range(0, 7) == 0);
            ioctl_addr = 25'($urandom_range(0, EXP - 1));
            tick();
            if (dn_wr || !core_reset || dl_done || dl_busy) viol++;
        end
        chk("boot_quiet", viol, 0);
        soft_rst = 0; ioctl_wr = 0;

        // Full image; the last byte arrives on the download-fall cycle.
        ioctl_download = 1;
        tick();
        chk("full_busy", dl_busy, 1);
        viol = 0;
        for (int a = 0; a < EXP; a++) begin
            d = 8'($urandom);
            ioctl_download = (a != EXP - 1);
            ioctl_wr = 1; ioctl_addr = 25'(a); ioctl_dout = d;
            tick();
            if (!dn_wr || dn_addr != 16'(a) || dn_data != d || rgn_sel != region(a)) viol++;
            if (a == 'h3FFF) chk("rgn_3fff", rgn_sel, 0);
            if (a == 'h4000) chk("rgn_4000", rgn_sel, 1);
            if (a == 'h6000) chk("rgn_6000", rgn_sel, 2);
        end
        chk("full_writes", viol, 0);
        chk("full_fall_wr", dn_wr, 1);
        ioctl_wr = 0;
        chk("full_err", dl_err, 0);
        wait_run("full_hold", HOLD);
        chk("full_done", dl_done, 1);
        chk("full_err_run", dl_err, 0);

        // Strobes in RUN are ignored.
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            ioctl_wr = $urandom_range(0, 1);
            ioctl_addr = 25'($urandom_range(0, EXP - 1));
            tick();
            if (dn_wr || core_reset) viol++;
        end
        chk("run_ignore_wr", viol, 0);
        ioctl_wr = 0;

        // Soft reset held 50 cycles stretches to 50+HOLD with no gap.
        begin
            int n = 0;
            viol = 0;
            for (int i = 0; i < 3000; i++) begin
                soft_rst = (i < 50);
                #1;
                if (!core_reset) break;
                n++;
                if (!dl_done) viol++;
                tick();
            end
            chk("soft_len", n, 50 + HOLD);
            chk("soft_done", viol, 0);
            soft_rst = 0;
        end

        // Short image of 100 random in-range bytes.
        ioctl_download = 1;
        tick();
        chk("short_busy", dl_busy, 1);
        chk("short_done_clr", dl_done, 0);
        sent = 0; viol = 0;
        while (sent < 100) begin
            ioctl_wr = $urandom_range(0, 1);
            ioctl_addr = 25'($urandom_range(0, EXP - 1));
            d = 8'($urandom);
            ioctl_dout = d;
            tick();
            if (ioctl_wr) begin
                sent++;
                if (!dn_wr || dn_addr != ioctl_addr[15:0] || dn_data != d ||
                    rgn_sel != region(int'(ioctl_addr))) viol++;
            end else if (dn_wr) viol++;
        end
        chk("short_writes", viol, 0);
        ioctl_wr = 0; ioctl_download = 0;
        tick();
        chk("short_err", dl_err, 1);
        wait_run("short_hold", HOLD);
        chk("short_done", dl_done, 1);
        chk("short_err_run", dl_err, 1);

        // Reload from RUN clears status; then the region/range vector table.
        ioctl_download = 1;
        tick();
        chk("reload_busy", dl_busy, 1);
        chk("reload_done", dl_done, 0);
        chk("reload_err", dl_err, 0);
        chk("reload_core", core_reset, 1);
        foreach (vt[i]) begin
            ioctl_wr = 1; ioctl_addr = vt[i].addr; ioctl_dout = vt[i].data;
            tick();
            chk($sformatf("vec%0d_wr", i), dn_wr, vt[i].exp_wr);
            chk($sformatf("vec%0d_rgn", i), rgn_sel, vt[i].exp_rgn);
            chk($sformatf("vec%0d_err", i), dl_err, vt[i].exp_err);
            if (vt[i].exp_wr) begin
                chk($sformatf("vec%0d_addr", i), dn_addr, 32'(vt[i].addr[15:0]));
                chk($sformatf("vec%0d_data", i), dn_data, vt[i].data);
            end
        end
        ioctl_wr = 0;
        tick();
        chk("wr_pulse", dn_wr, 0);

        // Random traffic incl. out-of-range addresses in a fresh load.
        ioctl_download = 0;
        tick();
        ioctl_download = 1;
        tick();
        err_m = 0; viol = 0;
        for (int i = 0; i < 300; i++) begin
            logic ok;
            ioctl_wr = $urandom_range(0, 1);
            ioctl_addr = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(EXP, 'h1FFFFFF))
                                                     : 25'($urandom_range(0, EXP - 1));
            d = 8'($urandom);
            ioctl_dout = d;
            ok = ioctl_wr && (int'(ioctl_addr) < EXP);
            if (ioctl_wr && !ok) err_m = 1;
            tick();
            if (dn_wr != ok || dl_err != err_m) viol++;
            if (ok && (dn_addr != ioctl_addr[15:0] || dn_data != d)) viol++;
        end
        chk("rand_load", viol, 0);

        // Async reset with a write in flight.
        ioctl_wr = 1; ioctl_addr = 25'h5; ioctl_dout = 8'h5A;
        tick();
        chk("pre_rst_wr", dn_wr, 1);
        RESET = 1;
        #1;
        chk_reset_vals("async_rst");
        ioctl_wr = 0; ioctl_download = 0;
        tick();
        RESET = 0;
        tick();
        chk("post_rst_busy", dl_busy, 0);
        chk("post_rst_core", core_reset, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_dl_ctrl.md
Name: rom_dl_ctrl

Overview:
Download sequencer between the HPS ioctl stream and the arcade core's ROM write port (dn_addr/dn_data/dn_wr) and core reset. It registers and range-checks each downloaded byte and decodes it into a ROM region. It holds the core in reset from power-up until a complete download has landed, then for a fixed settling time. It also stretches menu/button soft resets through the same hold path.

Parameters:
EXP_BYTES, 32768, required image size in bytes; valid addresses are 0..EXP_BYTES-1
RGN1_BASE, 16'h4000, first address of region 1; region 0 is below this
RGN2_BASE, 16'h6000, first address of region 2; region 2 runs from here to EXP_BYTES-1
HOLD_CYCLES, 1024, core reset hold length in CLK cycles after download end or soft reset (must be >=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous active-high reset
ioctl_download  in  1  high while a download is in progress
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
soft_rst  in  1  level soft-reset request (status/button OR)
dn_addr  out  16  registered ROM write address
dn_data  out  8  registered ROM write data
dn_wr  out  1  registered ROM write strobe
rgn_sel  out  2  region of the current dn_addr: 0, 1 or 2
core_reset  out  1  reset to the arcade core
dl_busy  out  1  high in LOAD
dl_done  out  1  high in RUN after at least one completed download
dl_err  out  1  sticky error for the last download

Behaviour:
- Reset values: state BOOT; dn_addr=0; dn_data=0; dn_wr=0; rgn_sel=0; core_reset=1; dl_busy=0; dl_done=0; dl_err=0; byte_cnt=0; hold_cnt=0.
- The state machine has four states: BOOT, LOAD, HOLD and RUN. core_reset=1 in BOOT, LOAD and HOLD. In RUN, core_reset=soft_rst.
- BOOT:
  - ioctl_download=1 -> LOAD.
  - soft_rst is ignored.
- Entry to LOAD, from any state:
  - byte_cnt=0, dl_err=0, dl_done=0, dl_busy=1.
- LOAD, on ioctl_wr=1:
  - If ioctl_addr<EXP_BYTES: next cycle dn_wr=1, dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout, rgn_sel decoded from ioctl_addr. Latency is exactly 1 cycle, and dn_wr is a single-cycle pulse per strobe.
  - If ioctl_addr>=EXP_BYTES: the write is dropped (dn_wr stays 0) and dl_err=1.
  - byte_cnt increments on every strobe, accepted or dropped. It is 17 bits and saturates at all-ones.
- LOAD, on ioctl_download=0:
  - -> HOLD with hold_cnt=HOLD_CYCLES-1.
  - dl_err |= (byte_cnt != EXP_BYTES), evaluated including any strobe in that same cycle.
  - A strobe coinciding with the falling download is accepted and counted.
- HOLD:
  - hold_cnt decrements each cycle. At hold_cnt==0 -> RUN, core_reset falls on the next cycle, dl_done=1.
  - ioctl_download=1 -> LOAD. This takes priority over the counter.
  - soft_rst=1 reloads hold_cnt=HOLD_CYCLES-1.
- RUN:
  - ioctl_download=1 -> LOAD (priority over soft_rst).
  - A soft_rst rising edge -> HOLD with hold_cnt=HOLD_CYCLES-1. dl_done stays 1. core_reset stays 1 continuously from the soft_rst assertion through HOLD.
- rgn_sel decode: addr<RGN1_BASE -> 0; addr<RGN2_BASE -> 1; else 2. rgn_sel updates only with dn_wr and holds otherwise.
- ioctl_wr outside LOAD is ignored: no dn_wr, no count.
- dl_err holds its value through HOLD and RUN until the next LOAD entry.
- Asynchronous RESET mid-LOAD returns to BOOT immediately. Any dn_wr in flight is cleared.
- Total hold length: core_reset stays high for exactly HOLD_CYCLES cycles after the cycle ioctl_download is sampled low.

Test Plan:
- Power-up: RESET pulse, no download, 10000 cycles -> core_reset=1, dl_done=0, dn_wr never asserts; soft_rst pulses have no effect.
- Full load, EXP_BYTES=32768, HOLD_CYCLES=1024: 32768 strobes at addr 0..32767, then download low -> each dn_wr one cycle after its strobe with matching addr/data. Region checks: addr 0x3FFF -> rgn_sel=0, 0x4000 -> 1, 0x6000 -> 2. Then core_reset low exactly 1024 cycles after download falls, dl_done=1, dl_err=0.
- Short image: 100 bytes, then download low -> dl_err=1 after the falling edge; RUN still reached after the hold.
- Out-of-range: strobe at addr 0x8000 with data 0xAA -> no dn_wr, dl_err=1, byte_cnt increments; a strobe on the download-fall cycle is counted and written.
- Soft reset: in RUN, assert soft_rst for 50 cycles -> core_reset=1 for 50+1024 cycles with no gap; dl_done stays 1.
- Reload and async reset: download rises in RUN -> LOAD, dl_done=0, dl_err cleared, core_reset=1. Assert RESET mid-LOAD -> BOOT, all outputs at reset values in the same cycle.
